// File: rtl/retire_unit_if.sv
// Shared retire types plus the bundle of ROB/LSQ/register-file/memory signals
// that connect the retire unit to the rest of the core.
package retire_pkg;
  typedef logic [4:0]  Register;
  typedef logic [31:0] MemoryWord;
  typedef logic [3:0]  tag_t;

  typedef struct packed {
    logic regwr;
    logic memwr;
  } ctrl_t;

  typedef struct packed {
    logic      ready;
    tag_t      tag;
    ctrl_t     ctrl_bits;
    Register   rd;
    MemoryWord value;
  } rob_entry;

  typedef struct packed {
    tag_t      tag;
    MemoryWord addr;
    MemoryWord data;
  } lsq_entry;
endpackage

interface retire_unit_if #(parameter int RETIRE_WIDTH = 2);
  import retire_pkg::*;
  localparam int DEC_W = $clog2(RETIRE_WIDTH + 1);

  rob_entry  [RETIRE_WIDTH-1:0] rob_head;
  lsq_entry                     lsq_head;
  logic                         st_ack;
  logic      [DEC_W-1:0]        rob_decrement;
  logic                         lsq_decrement;
  logic      [RETIRE_WIDTH-1:0] regwr;
  Register   [RETIRE_WIDTH-1:0] rd;
  MemoryWord [RETIRE_WIDTH-1:0] value;
  rob_entry  [RETIRE_WIDTH-1:0] re;
  lsq_entry                     le;
  logic                         st_req;

  modport master (
    output rob_head, lsq_head, st_ack,
    input  rob_decrement, lsq_decrement, regwr, rd, value, re, le, st_req
  );

  modport slave (
    input  rob_head, lsq_head, st_ack,
    output rob_decrement, lsq_decrement, regwr, rd, value, re, le, st_req
  );
endinterface

// File: rtl/retire_unit.sv
// In-order retire stage: pops up to RETIRE_WIDTH ready ROB entries per cycle and
// commits stores via a request/ack handshake. Optional RETIRE_STATS_EN adds retired_count.
module retire_unit
  import retire_pkg::*;
#(
  parameter int RETIRE_WIDTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  retire_unit_if.slave  bus
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]   retired_count
`endif
);

  localparam int DEC_W = $clog2(RETIRE_WIDTH + 1);

  typedef enum logic {IDLE, STORE_WAIT} state_e;

  state_e                  state;
  state_e                  next_state;
  logic [RETIRE_WIDTH-1:0] retire;
  logic [DEC_W-1:0]        count;
  logic                    load_hit;
  logic                    store_hit;
  logic                    blocked;
  logic                    seen_mem;
  logic                    is_mem;

  // Retire group grows from the head and stops at the first non-ready slot,
  // a second memory op, or right after a store.
  always_comb begin
    retire    = '0;
    count     = '0;
    load_hit  = 1'b0;
    store_hit = 1'b0;
    seen_mem  = 1'b0;
    is_mem    = 1'b0;
    blocked   = (state != IDLE);
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      is_mem = (bus.rob_head[i].tag == bus.lsq_head.tag);
      if (!blocked && bus.rob_head[i].ready && !(is_mem && seen_mem)) begin
        retire[i] = 1'b1;
        count     = count + DEC_W'(1);
        if (is_mem) begin
          seen_mem = 1'b1;
          if (bus.rob_head[i].ctrl_bits.memwr) begin
            store_hit = 1'b1;
            blocked   = 1'b1;
          end else begin
            load_hit = 1'b1;
          end
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (store_hit)  next_state = STORE_WAIT;
      STORE_WAIT: if (bus.st_ack) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Pop counts are combinational but forced to zero while reset is held.
  always_comb begin
    bus.rob_decrement = '0;
    bus.lsq_decrement = 1'b0;
    if (reset) begin
      bus.rob_decrement = count;
      case (state)
        IDLE:       bus.lsq_decrement = load_hit;
        STORE_WAIT: bus.lsq_decrement = bus.st_ack;
        default:    bus.lsq_decrement = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.regwr <= '0;
      bus.rd    <= '0;
      bus.value <= '0;
      bus.re    <= '0;
    end else begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        bus.regwr[i] <= retire[i] & bus.rob_head[i].ctrl_bits.regwr;
        bus.rd[i]    <= retire[i] ? bus.rob_head[i].rd    : '0;
        bus.value[i] <= retire[i] ? bus.rob_head[i].value : '0;
        bus.re[i]    <= retire[i] ? bus.rob_head[i]       : '0;
      end
    end
  end

  // The committed store is captured once and held until memory acknowledges it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.st_req <= 1'b0;
      bus.le     <= '0;
    end else begin
      bus.st_req <= (next_state == STORE_WAIT);
      if (state == IDLE && next_state == STORE_WAIT) bus.le <= bus.lsq_head;
      else if (next_state == IDLE)                  bus.le <= '0;
    end
  end

`ifdef RETIRE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_count <= '0;
    else        retired_count <= retired_count + 32'(bus.rob_decrement);
  end
`endif

endmodule
